// File: rtl/vape_pkg.sv
// vape_pkg: codebase-wide constants for the VAPE/APEX EXEC stage.
//   - FSM state encodings (2-bit; 3 is illegal and decays to KILL)
//   - reset handler address
//   - fixed monitor wiring order for the mon_exec vector
package vape_pkg;

  localparam logic [1:0] ST_KILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // CPU reset vector target; execution starting here is never part of the ER.
  localparam logic [15:0] RESET_HANDLER = 16'hFFFE;

  // Bit positions in mon_exec. Every producer and consumer uses these.
  localparam int MON_IVT  = 0;
  localparam int MON_ER   = 1;
  localparam int MON_ATOM = 2;
  localparam int MON_DMA  = 3;

endpackage

// File: rtl/vape_viol_diag.sv
// vape_viol_diag: violation diagnostics for the EXEC aggregator.
//   Records the first violating monitor set (sticky until cleared) and counts
//   kills with a saturating counter.
// Ports:
//   i_clk, i_reset      clock, async active-high reset
//   i_kill              one-cycle pulse on a RUN/DONE->KILL transition
//   i_clr               one-cycle diagnostic clear
//   i_cause_new         monitors currently reporting a violation (masked)
//   o_viol_cause        first recorded cause since last clear
//   o_viol_count        saturating kill count
module vape_viol_diag
  import vape_pkg::*;
#(
  parameter int N_MON = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_kill,
  input  logic             i_clr,
  input  logic [N_MON-1:0] i_cause_new,
  output logic [N_MON-1:0] o_viol_cause,
  output logic [CNT_W-1:0] o_viol_count
);

  logic [N_MON-1:0] r_cause;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cause <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      // A clear discards history, but a kill on the same edge still counts
      // as the first event of the new window.
      r_cause <= i_kill ? i_cause_new : '0;
      r_count <= i_kill ? CNT_W'(1) : '0;
    end else if (i_kill) begin
      // For exits/config kills with all monitors ok, i_cause_new is zero,
      // so the cause register stays clear and a later monitor kill can load.
      if (r_cause == '0) r_cause <= i_cause_new;
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_viol_cause = r_cause;
  assign o_viol_count = r_count;

endmodule

// File: rtl/vape_exec_aggregator.sv
// vape_exec_aggregator: final EXEC-flag stage of the VAPE/APEX monitor.
//   Combines the upstream monitor exec bits with an ER-execution FSM and
//   produces the attested EXEC flag plus violation diagnostics.
// Ports:
//   i_clk, i_reset      clock, async active-high reset
//   i_pc                current CPU program counter
//   i_er_min/i_er_max   ER entry point / legal exit (inclusive bounds)
//   i_mon_exec          per-monitor exec bits, 1 = no violation
//   i_diag_clr          one-cycle clear of the diagnostics
//   o_exec              attested EXEC flag (registered)
//   o_state             FSM state for debug
//   o_viol_cause        first violating monitor(s) since last clear
//   o_viol_count        saturating count of RUN/DONE->KILL transitions
module vape_exec_aggregator
  import vape_pkg::*;
#(
  parameter int               N_MON    = 4,
  parameter logic [N_MON-1:0] MON_MASK = {N_MON{1'b1}},
  parameter int               CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [15:0]      i_pc,
  input  logic [15:0]      i_er_min,
  input  logic [15:0]      i_er_max,
  input  logic [N_MON-1:0] i_mon_exec,
  input  logic             i_diag_clr,
  output logic             o_exec,
  output logic [1:0]       o_state,
  output logic [N_MON-1:0] o_viol_cause,
  output logic [CNT_W-1:0] o_viol_count
);

  logic [1:0]       r_state;
  logic             r_exec;
  logic [1:0]       w_next;
  logic             w_ok;
  logic             w_cfg_bad;
  logic             w_in_er;
  logic             w_kill;
  logic [N_MON-1:0] w_cause_new;

  // Masked-off monitors read as permanently ok.
  assign w_ok        = &(i_mon_exec | ~MON_MASK);
  assign w_cause_new = ~i_mon_exec & MON_MASK;
  assign w_cfg_bad   = (i_er_min > i_er_max);
  assign w_in_er     = (i_pc >= i_er_min) && (i_pc <= i_er_max);

  always_comb begin
    w_next = ST_KILL;
    if (w_cfg_bad) begin
      w_next = ST_KILL;
    end else begin
      case (r_state)
        ST_KILL: w_next = (i_pc == i_er_min && w_ok) ? ST_RUN : ST_KILL;
        ST_RUN: begin
          if (!w_ok)                 w_next = ST_KILL;
          else if (!w_in_er)         w_next = ST_KILL;
          else if (i_pc == i_er_max) w_next = ST_DONE;
          else                       w_next = ST_RUN;
        end
        ST_DONE: begin
          // Leaving the ER after a legal exit is allowed; only a monitor
          // violation or re-entry changes state.
          if (!w_ok)                 w_next = ST_KILL;
          else if (i_pc == i_er_min) w_next = ST_RUN;
          else                       w_next = ST_DONE;
        end
        default: w_next = ST_KILL;
      endcase
    end
  end

  // KILL->KILL is deliberately not a kill event.
  assign w_kill = ((r_state == ST_RUN) || (r_state == ST_DONE)) && (w_next == ST_KILL);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_KILL;
      r_exec  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_exec  <= (w_next != ST_KILL);
    end
  end

  vape_viol_diag #(
    .N_MON (N_MON),
    .CNT_W (CNT_W)
  ) u_diag (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_kill       (w_kill),
    .i_clr        (i_diag_clr),
    .i_cause_new  (w_cause_new),
    .o_viol_cause (o_viol_cause),
    .o_viol_count (o_viol_count)
  );

  assign o_exec  = r_exec;
  assign o_state = r_state;

endmodule

// File: tb/tb_vape_exec_aggregator.sv
// Directed bench for vape_exec_aggregator: a default instance, a CNT_W=2
// instance for saturation and a MON_MASK=4'hE instance for masking, all
// driven from the same stimulus.
module tb_vape_exec_aggregator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [15:0] er_min = 16'hE000;
  logic [15:0] er_max = 16'hE0FE;
  logic [3:0]  mon = 4'hF;
  logic        clr = 1'b0;

  logic       exec_a, exec_s, exec_m;
  logic [1:0] st_a, st_s, st_m;
  logic [3:0] cause_a, cause_s, cause_m;
  logic [7:0] cnt_a, cnt_m;
  logic [1:0] cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vape_exec_aggregator u_dut (
    .i_clk(clk), .i_reset(reset), .i_pc(pc), .i_er_min(er_min), .i_er_max(er_max),
    .i_mon_exec(mon), .i_diag_clr(clr), .o_exec(exec_a), .o_state(st_a),
    .o_viol_cause(cause_a), .o_viol_count(cnt_a)
  );

  vape_exec_aggregator #(.CNT_W(2)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_pc(pc), .i_er_min(er_min), .i_er_max(er_max),
    .i_mon_exec(mon), .i_diag_clr(clr), .o_exec(exec_s), .o_state(st_s),
    .o_viol_cause(cause_s), .o_viol_count(cnt_s)
  );

  vape_exec_aggregator #(.MON_MASK(4'hE)) u_mask (
    .i_clk(clk), .i_reset(reset), .i_pc(pc), .i_er_min(er_min), .i_er_max(er_max),
    .i_mon_exec(mon), .i_diag_clr(clr), .o_exec(exec_m), .o_state(st_m),
    .o_viol_cause(cause_m), .o_viol_count(cnt_m)
  );

  // Apply inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [15:0] p, input logic [3:0] m, input logic c);
    @(negedge clk);
    pc = p; mon = m; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; pc = 16'h0000; mon = 4'hF; clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    #1;
    n_tests++; if (exec_a !== 1'b0) begin n_fail++; $display("FAIL reset_exec got %b want 0", exec_a); end
    n_tests++; if (st_a !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st_a); end
    n_tests++; if (cause_a !== 4'h0) begin n_fail++; $display("FAIL reset_cause got %h want 0", cause_a); end
    n_tests++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt_a); end
    reset = 1'b0;
  endtask

  task automatic test_normal_run();
    int bad_run;
    er_min = 16'hE000; er_max = 16'hE0FE;
    step(16'hC000, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b0) begin n_fail++; $display("FAIL normal_pre_exec got %b want 0", exec_a); end
    step(16'hE000, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b1 || st_a !== 2'd1) begin n_fail++; $display("FAIL normal_entry got exec=%b st=%0d want exec=1 st=1", exec_a, st_a); end
    bad_run = 0;
    for (int a = 16'hE002; a <= 16'hE0FC; a += 2) begin
      step(16'(a), 4'hF, 1'b0);
      if (exec_a !== 1'b1 || st_a !== 2'd1) bad_run++;
    end
    n_tests++; if (bad_run != 0) begin n_fail++; $display("FAIL normal_body got %0d bad cycles want 0", bad_run); end
    step(16'hE0FE, 4'hF, 1'b0);
    n_tests++; if (st_a !== 2'd2 || exec_a !== 1'b1) begin n_fail++; $display("FAIL normal_done got exec=%b st=%0d want exec=1 st=2", exec_a, st_a); end
    step(16'hC000, 4'hF, 1'b0);
    n_tests++; if (st_a !== 2'd2 || exec_a !== 1'b1) begin n_fail++; $display("FAIL normal_after_exit got exec=%b st=%0d want exec=1 st=2", exec_a, st_a); end
    n_tests++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL normal_count got %0d want 0", cnt_a); end
  endtask

  task automatic test_ivt_violation();
    step(16'hE000, 4'hF, 1'b0);
    n_tests++; if (st_a !== 2'd1 || exec_a !== 1'b1) begin n_fail++; $display("FAIL ivt_reentry_from_done got exec=%b st=%0d want exec=1 st=1", exec_a, st_a); end
    step(16'hE002, 4'hE, 1'b0);
    n_tests++; if (exec_a !== 1'b0 || st_a !== 2'd0) begin n_fail++; $display("FAIL ivt_kill got exec=%b st=%0d want exec=0 st=0", exec_a, st_a); end
    n_tests++; if (cause_a !== 4'b0001 || cnt_a !== 8'd1) begin n_fail++; $display("FAIL ivt_diag got cause=%b cnt=%0d want cause=0001 cnt=1", cause_a, cnt_a); end
    step(16'hE004, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b0) begin n_fail++; $display("FAIL ivt_stays_killed got %b want 0", exec_a); end
    step(16'hE000, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b1 || st_a !== 2'd1) begin n_fail++; $display("FAIL ivt_reentry got exec=%b st=%0d want exec=1 st=1", exec_a, st_a); end
  endtask

  task automatic test_illegal_exit();
    step(16'hE010, 4'hF, 1'b1);
    n_tests++; if (cause_a !== 4'h0 || cnt_a !== 8'd0 || st_a !== 2'd1) begin n_fail++; $display("FAIL exit_clear got cause=%b cnt=%0d st=%0d want 0 0 1", cause_a, cnt_a, st_a); end
    step(16'h8000, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b0 || st_a !== 2'd0) begin n_fail++; $display("FAIL exit_kill got exec=%b st=%0d want exec=0 st=0", exec_a, st_a); end
    n_tests++; if (cause_a !== 4'h0 || cnt_a !== 8'd1) begin n_fail++; $display("FAIL exit_diag got cause=%b cnt=%0d want cause=0000 cnt=1", cause_a, cnt_a); end
  endtask

  task automatic test_sticky_saturation();
    pulse_reset();
    er_min = 16'hE000; er_max = 16'hE0FE;
    step(16'hE000, 4'hF, 1'b0);
    step(16'hE002, 4'hD, 1'b0);
    n_tests++; if (cause_s !== 4'b0010 || cnt_s !== 2'd1) begin n_fail++; $display("FAIL sat_first got cause=%b cnt=%0d want 0010 1", cause_s, cnt_s); end
    for (int k = 0; k < 3; k++) begin
      step(16'hE000, 4'hF, 1'b0);
      step(16'hE002, 4'h7, 1'b0);
    end
    n_tests++; if (cause_s !== 4'b0010) begin n_fail++; $display("FAIL sat_sticky got cause=%b want 0010", cause_s); end
    n_tests++; if (cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d want 3", cnt_s); end
    n_tests++; if (cnt_a !== 8'd4) begin n_fail++; $display("FAIL wide_count got %0d want 4", cnt_a); end
    step(16'h0000, 4'hF, 1'b1);
    n_tests++; if (cause_s !== 4'h0 || cnt_s !== 2'd0) begin n_fail++; $display("FAIL sat_clear got cause=%b cnt=%0d want 0 0", cause_s, cnt_s); end
    step(16'hE000, 4'hF, 1'b0);
    step(16'hE002, 4'hB, 1'b1);
    n_tests++; if (cause_s !== 4'b0100 || cnt_s !== 2'd1) begin n_fail++; $display("FAIL clr_and_kill got cause=%b cnt=%0d want 0100 1", cause_s, cnt_s); end
  endtask

  task automatic test_config_bad();
    er_min = 16'hE100; er_max = 16'hE000;
    step(16'hE100, 4'hF, 1'b0);
    step(16'hE100, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b0 || st_a !== 2'd0) begin n_fail++; $display("FAIL cfg_no_entry got exec=%b st=%0d want 0 0", exec_a, st_a); end
    er_min = 16'hE000; er_max = 16'hE0FE;
    step(16'hE000, 4'hF, 1'b1);
    n_tests++; if (exec_a !== 1'b1 || cnt_a !== 8'd0) begin n_fail++; $display("FAIL cfg_entry got exec=%b cnt=%0d want 1 0", exec_a, cnt_a); end
    er_min = 16'hE100;
    step(16'hE010, 4'hF, 1'b0);
    n_tests++; if (exec_a !== 1'b0 || cause_a !== 4'h0 || cnt_a !== 8'd1) begin n_fail++; $display("FAIL cfg_kill got exec=%b cause=%b cnt=%0d want 0 0000 1", exec_a, cause_a, cnt_a); end
  endtask

  task automatic test_mask();
    pulse_reset();
    er_min = 16'hE000; er_max = 16'hE0FE;
    step(16'hE000, 4'hE, 1'b0);
    n_tests++; if (st_m !== 2'd1 || exec_m !== 1'b1) begin n_fail++; $display("FAIL mask_entry got exec=%b st=%0d want 1 1", exec_m, st_m); end
    n_tests++; if (st_a !== 2'd0 || exec_a !== 1'b0) begin n_fail++; $display("FAIL unmasked_blocked got exec=%b st=%0d want 0 0", exec_a, st_a); end
    step(16'hE002, 4'hE, 1'b0);
    n_tests++; if (st_m !== 2'd1 || cnt_m !== 8'd0) begin n_fail++; $display("FAIL mask_run got st=%0d cnt=%0d want 1 0", st_m, cnt_m); end
  endtask

  task automatic test_single_instr();
    er_min = 16'hE200; er_max = 16'hE200;
    step(16'hE200, 4'hF, 1'b0);
    n_tests++; if (st_a !== 2'd1) begin n_fail++; $display("FAIL single_run got %0d want 1", st_a); end
    step(16'hE200, 4'hF, 1'b0);
    n_tests++; if (st_a !== 2'd2 || exec_a !== 1'b1) begin n_fail++; $display("FAIL single_done got exec=%b st=%0d want 1 2", exec_a, st_a); end
    step(16'hE200, 4'hE, 1'b0);
    n_tests++; if (st_a !== 2'd0 || cause_a !== 4'b0001 || cnt_a !== 8'd1) begin n_fail++; $display("FAIL done_kill got st=%0d cause=%b cnt=%0d want 0 0001 1", st_a, cause_a, cnt_a); end
    step(16'hE200, 4'hF, 1'b0);
    step(16'hE200, 4'hF, 1'b0);
  endtask

  task automatic test_async_reset();
    n_tests++; if (st_a !== 2'd2 || exec_a !== 1'b1) begin n_fail++; $display("FAIL areset_pre got exec=%b st=%0d want 1 2", exec_a, st_a); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (exec_a !== 1'b0 || st_a !== 2'd0) begin n_fail++; $display("FAIL areset_exec got exec=%b st=%0d want 0 0", exec_a, st_a); end
    n_tests++; if (cause_a !== 4'h0 || cnt_a !== 8'd0) begin n_fail++; $display("FAIL areset_diag got cause=%b cnt=%0d want 0 0", cause_a, cnt_a); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_ivt_violation();
    test_illegal_exit();
    test_sticky_saturation();
    test_config_bad();
    test_mask();
    test_single_instr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
